// File: rtl/coin_return_dispenser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : coin_return_dispenser_pkg
// Purpose  : Shared vending-machine definitions: coin count, datapath width,
//            coin denominations and the payout state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package coin_return_dispenser_pkg;

  localparam int kNumCoins  = 3;
  localparam int kTotalBits = 31;

  // Denominations, smallest first. The selector relies on ascending order.
  localparam int kCoinVal0 = 100;
  localparam int kCoinVal1 = 500;
  localparam int kCoinVal2 = 1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PICK  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage : coin_return_dispenser_pkg
`default_nettype wire

// File: rtl/coin_return_dispenser_coin_select.sv
`default_nettype none
// ============================================================================
// Module   : coin_return_dispenser_coin_select
// Purpose  : Combinational largest-fit picker. Returns the largest available
//            denomination whose value does not exceed the balance.
// Ports    : i_balance   - balance still to be paid
//            i_avail     - per-denomination availability mask
//            o_onehot    - one-hot code of the chosen coin (0 if none)
//            o_value     - value of the chosen coin (0 if none)
//            o_found     - a coin was chosen
// Revision : 1.0 - initial release
// ============================================================================
module coin_return_dispenser_coin_select
  import coin_return_dispenser_pkg::*;
#(
  parameter int NUM_COINS  = kNumCoins,
  parameter int TOTAL_BITS = kTotalBits,
  // Packed coin values, index 0 in the least-significant slot, ascending.
  parameter logic [NUM_COINS*TOTAL_BITS-1:0] COIN_VALS = '0
) (
  input  logic [TOTAL_BITS-1:0] i_balance,
  input  logic [NUM_COINS-1:0]  i_avail,
  output logic [NUM_COINS-1:0]  o_onehot,
  output logic [TOTAL_BITS-1:0] o_value,
  output logic                  o_found
);

  // Scan smallest to largest; because values ascend, the last fit wins and
  // is therefore the largest fitting denomination.
  always_comb begin
    o_onehot = '0;
    o_value  = '0;
    o_found  = 1'b0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (i_avail[i] && (COIN_VALS[i*TOTAL_BITS +: TOTAL_BITS] <= i_balance)) begin
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
        o_value     = COIN_VALS[i*TOTAL_BITS +: TOTAL_BITS];
        o_found     = 1'b1;
      end
    end
  end

endmodule : coin_return_dispenser_coin_select
`default_nettype wire

// File: rtl/coin_return_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : coin_return_dispenser
// Purpose  : On a return request, latches the current total and pays it out
//            as coins, largest denomination first, one coin per hopper
//            ready/valid handshake. Each dispensed coin is reported as a
//            deduction; completion is flagged with a done pulse and the
//            unpayable remainder.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            i_return_req          - one-cycle payout request
//            i_current_total       - balance, sampled with i_return_req
//            o_hopper_valid/coin   - coin offered to the hopper (one-hot)
//            i_hopper_ready        - hopper accepts the offered coin
//            o_dec_valid/amount    - deduction pulse and coin value
//            o_busy                - payout in progress
//            o_done/o_remainder    - completion pulse and unpaid balance
//            i_refill              - per-coin refill pulse (inventory only)
// Options  : COIN_INVENTORY_EN - track a per-denomination coin inventory;
//            empty denominations are skipped, refill sets a counter full.
// Revision : 1.0 - initial release
// ============================================================================
module coin_return_dispenser
  import coin_return_dispenser_pkg::*;
#(
  parameter int NUM_COINS  = kNumCoins,
  parameter int TOTAL_BITS = kTotalBits,
  parameter int COIN_VAL0  = kCoinVal0,
  parameter int COIN_VAL1  = kCoinVal1,
  parameter int COIN_VAL2  = kCoinVal2,
  parameter int INV_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_return_req,
  input  logic [TOTAL_BITS-1:0] i_current_total,
  output logic                  o_hopper_valid,
  output logic [NUM_COINS-1:0]  o_hopper_coin,
  input  logic                  i_hopper_ready,
`ifdef COIN_INVENTORY_EN
  input  logic [NUM_COINS-1:0]  i_refill,
`endif
  output logic                  o_dec_valid,
  output logic [TOTAL_BITS-1:0] o_dec_amount,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [TOTAL_BITS-1:0] o_remainder
);

  // Three denominations are packed here; NUM_COINS is expected to be 3.
  localparam logic [NUM_COINS*TOTAL_BITS-1:0] COIN_VALS = {
    TOTAL_BITS'(COIN_VAL2), TOTAL_BITS'(COIN_VAL1), TOTAL_BITS'(COIN_VAL0)
  };

  state_e                state_q, state_d;
  logic [TOTAL_BITS-1:0] balance_q, balance_d;
  logic [TOTAL_BITS-1:0] value_q, value_d;
  logic [NUM_COINS-1:0]  coin_q, coin_d;
  logic                  dec_valid_q, dec_valid_d;
  logic [TOTAL_BITS-1:0] dec_amount_q, dec_amount_d;
  logic [TOTAL_BITS-1:0] remainder_q, remainder_d;

  logic [NUM_COINS-1:0]  avail;
  logic [NUM_COINS-1:0]  sel_onehot;
  logic [TOTAL_BITS-1:0] sel_value;
  logic                  sel_found;
  logic                  handshake;

  assign handshake = (state_q == ST_ISSUE) && i_hopper_ready;

`ifdef COIN_INVENTORY_EN
  for (genvar k = 0; k < NUM_COINS; k++) begin : g_inv
    logic [INV_BITS-1:0] cnt_q;
    // Refill has priority over a same-cycle dispense of the same coin.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
      end else if (i_refill[k]) begin
        cnt_q <= '1;
      end else if (handshake && coin_q[k]) begin
        cnt_q <= cnt_q - INV_BITS'(1);
      end
    end
    assign avail[k] = |cnt_q;
  end
`else
  // Unlimited stock; a zero-width inventory would mean no coins at all.
  assign avail = {NUM_COINS{INV_BITS > 0}};
`endif

  coin_return_dispenser_coin_select #(
    .NUM_COINS  (NUM_COINS),
    .TOTAL_BITS (TOTAL_BITS),
    .COIN_VALS  (COIN_VALS)
  ) u_coin_select (
    .i_balance (balance_q),
    .i_avail   (avail),
    .o_onehot  (sel_onehot),
    .o_value   (sel_value),
    .o_found   (sel_found)
  );

  always_comb begin
    state_d      = state_q;
    balance_d    = balance_q;
    value_d      = value_q;
    coin_d       = coin_q;
    dec_valid_d  = 1'b0;
    dec_amount_d = dec_amount_q;
    remainder_d  = remainder_q;
    case (state_q)
      ST_IDLE: begin
        if (i_return_req) begin
          balance_d = i_current_total;
          state_d   = ST_PICK;
        end
      end
      ST_PICK: begin
        if (sel_found) begin
          coin_d  = sel_onehot;
          value_d = sel_value;
          state_d = ST_ISSUE;
        end else begin
          remainder_d = balance_q;
          state_d     = ST_DONE;
        end
      end
      ST_ISSUE: begin
        if (i_hopper_ready) begin
          // Selection guarantees value_q <= balance_q, so no underflow.
          balance_d    = balance_q - value_q;
          dec_valid_d  = 1'b1;
          dec_amount_d = value_q;
          coin_d       = '0;
          state_d      = ST_PICK;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      balance_q    <= '0;
      value_q      <= '0;
      coin_q       <= '0;
      dec_valid_q  <= 1'b0;
      dec_amount_q <= '0;
      remainder_q  <= '0;
    end else begin
      state_q      <= state_d;
      balance_q    <= balance_d;
      value_q      <= value_d;
      coin_q       <= coin_d;
      dec_valid_q  <= dec_valid_d;
      dec_amount_q <= dec_amount_d;
      remainder_q  <= remainder_d;
    end
  end

  // All outputs come straight from registers or decodes of the state register.
  assign o_hopper_valid = (state_q == ST_ISSUE);
  assign o_hopper_coin  = coin_q;
  assign o_dec_valid    = dec_valid_q;
  assign o_dec_amount   = dec_amount_q;
  assign o_busy         = (state_q != ST_IDLE);
  assign o_done         = (state_q == ST_DONE);
  assign o_remainder    = remainder_q;

endmodule : coin_return_dispenser
`default_nettype wire

// File: tb/tb_coin_return_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_coin_return_dispenser
// Purpose  : Self-checking bench for coin_return_dispenser. A greedy payout
//            model predicts the outputs every cycle; directed tests add
//            literal expectations for coin order, remainder and latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coin_return_dispenser;

  logic        clk;
  logic        reset;
  logic        i_return_req;
  logic [30:0] i_current_total;
  logic        o_hopper_valid;
  logic [2:0]  o_hopper_coin;
  logic        i_hopper_ready;
  logic        o_dec_valid;
  logic [30:0] o_dec_amount;
  logic        o_busy;
  logic        o_done;
  logic [30:0] o_remainder;
`ifdef COIN_INVENTORY_EN
  logic [2:0]  i_refill;
`endif

  coin_return_dispenser dut (
    .clk             (clk),
    .reset           (reset),
    .i_return_req    (i_return_req),
    .i_current_total (i_current_total),
    .o_hopper_valid  (o_hopper_valid),
    .o_hopper_coin   (o_hopper_coin),
    .i_hopper_ready  (i_hopper_ready),
`ifdef COIN_INVENTORY_EN
    .i_refill        (i_refill),
`endif
    .o_dec_valid     (o_dec_valid),
    .o_dec_amount    (o_dec_amount),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_remainder     (o_remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] onehot_of(input longint v);
    case (v)
      1000:    return 3'b100;
      500:     return 3'b010;
      100:     return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic longint value_of(input logic [2:0] c);
    case (c)
      3'b100:  return 1000;
      3'b010:  return 500;
      3'b001:  return 100;
      default: return -1;
    endcase
  endfunction

  // ---------------- model: greedy coin list, played out over time ---------
  // step: 0 idle, 1 choosing next coin, 2 offering head coin, 3 finishing
  int          m_step;
  longint      m_q[$];
  longint      m_left;
  logic        e_valid, e_dec_v, e_busy, e_done;
  logic [2:0]  e_coin;
  longint      e_dec_amt, e_rem;

  always @(posedge clk) begin
    if (reset) begin
      m_step = 0; m_q.delete(); m_left = 0;
      e_valid = 0; e_coin = 0; e_dec_v = 0; e_dec_amt = 0;
      e_busy = 0; e_done = 0; e_rem = 0;
    end else begin
      e_dec_v = 0;
      e_done  = 0;
      case (m_step)
        0: if (i_return_req) begin
             longint t;
             t = longint'(i_current_total);
             m_q.delete();
             repeat (int'(t / 1000)) m_q.push_back(1000);
             t = t % 1000;
             repeat (int'(t / 500)) m_q.push_back(500);
             t = t % 500;
             repeat (int'(t / 100)) m_q.push_back(100);
             m_left = t % 100;
             m_step = 1;
           end
        1: m_step = (m_q.size() > 0) ? 2 : 3;
        2: if (i_hopper_ready) begin
             e_dec_v   = 1;
             e_dec_amt = m_q.pop_front();
             m_step    = 1;
           end
        3: m_step = 0;
        default: m_step = 0;
      endcase
      e_busy  = (m_step != 0);
      e_valid = (m_step == 2);
      e_coin  = e_valid ? onehot_of(m_q[0]) : 3'b000;
      e_done  = (m_step == 3);
      if (e_done) e_rem = m_left;
    end
  end

  // ---------------- per-cycle compare against model -----------------------
  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("hopper_valid", o_hopper_valid, e_valid);
      chk("hopper_coin", o_hopper_coin, e_coin);
      chk("dec_valid", o_dec_valid, e_dec_v);
      if (e_dec_v) chk("dec_amount", o_dec_amount, e_dec_amt);
      chk("busy", o_busy, e_busy);
      chk("done", o_done, e_done);
      if (e_done) chk("remainder", o_remainder, e_rem);
    end
  end

  // ---------------- observation log for literal checks --------------------
  int     cnt = 0;
  longint log_q[$];
  int     n_dec, n_valid, done_cnt, req_cnt;
  logic   done_seen;
  longint done_rem;

  always @(posedge clk) cnt++;

  always @(negedge clk) begin
    if (!reset) begin
      if (o_hopper_valid && i_hopper_ready) log_q.push_back(value_of(o_hopper_coin));
      if (o_dec_valid) n_dec++;
      if (o_hopper_valid) n_valid++;
      if (o_done) begin
        done_seen = 1'b1;
        done_rem  = longint'(o_remainder);
        done_cnt  = cnt;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic start_req(input longint total);
    log_q.delete();
    n_dec = 0; n_valid = 0; done_seen = 1'b0; done_rem = -1;
    i_current_total = 31'(total);
    i_return_req    = 1'b1;
    req_cnt         = cnt;
    cyc();
    i_return_req    = 1'b0;
    i_current_total = 31'h5A5A; // must be ignored once sampled
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 60; i++) begin
      if (done_seen) break;
      cyc();
    end
    chk({name, "_done_seen"}, done_seen, 1'b1);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 10; i++) begin
      if (o_hopper_valid) break;
      cyc();
    end
    chk({name, "_valid_seen"}, o_hopper_valid, 1'b1);
  endtask

  task automatic chk_coins(input string name, input longint c0, input longint c1,
                           input longint c2, input int n);
    longint exp_c [3];
    exp_c[0] = c0; exp_c[1] = c1; exp_c[2] = c2;
    chk({name, "_ncoins"}, log_q.size(), n);
    for (int i = 0; i < n && i < log_q.size(); i++)
      chk({name, "_coin"}, log_q[i], exp_c[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; i_return_req = 1'b0; i_current_total = '0; i_hopper_ready = 1'b1;
`ifdef COIN_INVENTORY_EN
    i_refill = '0;
`endif
    repeat (2) cyc();
    reset  = 1'b0;
    cmp_en = 1'b1;
    chk("rst_valid", o_hopper_valid, 0);
    chk("rst_coin", o_hopper_coin, 0);
    chk("rst_dec_valid", o_dec_valid, 0);
    chk("rst_dec_amount", o_dec_amount, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_remainder", o_remainder, 0);
`ifdef COIN_INVENTORY_EN
    i_refill = '1; cyc(); i_refill = '0;
`endif
    cyc();

    // 1600, ready tied high
    start_req(1600);
    wait_done("t1600");
    chk_coins("t1600", 1000, 500, 100, 3);
    chk("t1600_ndec", n_dec, 3);
    chk("t1600_rem", done_rem, 0);
    cyc();

    // 2150 -> 1000, 1000, 100, remainder 50
    start_req(2150);
    wait_done("t2150");
    chk_coins("t2150", 1000, 1000, 100, 3);
    chk("t2150_rem", done_rem, 50);
    cyc();

    // 500 with ready held low three cycles
    i_hopper_ready = 1'b0;
    start_req(500);
    wait_valid("t500");
    for (int i = 0; i < 3; i++) begin
      chk("t500_stall_valid", o_hopper_valid, 1);
      chk("t500_stall_coin", o_hopper_coin, 3'b010);
      chk("t500_stall_ndec", n_dec, 0);
      cyc();
    end
    i_hopper_ready = 1'b1;
    wait_done("t500");
    chk_coins("t500", 500, 0, 0, 1);
    chk("t500_ndec", n_dec, 1);
    chk("t500_rem", done_rem, 0);
    cyc();

    // 0, with a second request while busy
    start_req(0);
    i_current_total = 31'd1600;
    i_return_req    = 1'b1;
    cyc();
    i_return_req    = 1'b0;
    wait_done("t0");
    chk("t0_latency", done_cnt - req_cnt, 2);
    chk("t0_rem", done_rem, 0);
    chk("t0_nvalid", n_valid, 0);
    repeat (3) cyc();
    chk("t0_idle_busy", o_busy, 0);

    // below smallest coin
    start_req(50);
    wait_done("t50");
    chk("t50_rem", done_rem, 50);
    chk("t50_nvalid", n_valid, 0);
    cyc();

    // reset while offering a coin
    i_hopper_ready = 1'b0;
    start_req(2000);
    wait_valid("trst");
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("trst_valid", o_hopper_valid, 0);
    chk("trst_coin", o_hopper_coin, 0);
    chk("trst_dec_valid", o_dec_valid, 0);
    chk("trst_dec_amount", o_dec_amount, 0);
    chk("trst_busy", o_busy, 0);
    chk("trst_done", o_done, 0);
    chk("trst_remainder", o_remainder, 0);
`ifdef COIN_INVENTORY_EN
    i_refill = '1; cyc(); i_refill = '0;
`endif
    i_hopper_ready = 1'b1;
    cyc();
    start_req(1600);
    wait_done("tpost");
    chk_coins("tpost", 1000, 500, 100, 3);
    chk("tpost_rem", done_rem, 0);
    repeat (2) cyc();

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_coin_return_dispenser
`default_nettype wire
